// File: rtl/ram_req_arbiter.sv
// rtl/ram_req_arbiter.sv - round-robin arbiter for one RAM port with read routing and write hazard blocking (optional ECC status: ARB_ECC_EN)
module ram_req_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               i_req,
  input  logic [NUM_REQ-1:0]               i_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    i_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_din,
  output logic [NUM_REQ-1:0]               o_gnt,
  output logic                             o_ram_en,
  output logic                             o_ram_we,
  output logic [ADDR_WIDTH-1:0]            o_ram_addr,
  output logic [DATA_WIDTH-1:0]            o_ram_din,
  input  logic [DATA_WIDTH-1:0]            i_ram_dout,
`ifdef ARB_ECC_EN
  input  logic [1:0]                       i_ram_error,
  output logic [1:0]                       o_rerror,
  output logic [7:0]                       o_err_cnt,
`endif
  output logic [NUM_REQ-1:0]               o_rvalid,
  output logic [DATA_WIDTH-1:0]            o_rdata
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // round-robin pointer: first requester examined in the next search
  logic [IDW-1:0]                          r_ptr;

  // registered RAM command
  logic                                    r_ram_en;
  logic                                    r_ram_we;
  logic [ADDR_WIDTH-1:0]                   r_ram_addr;
  logic [DATA_WIDTH-1:0]                   r_ram_din;

  // read tag pipeline: stage RD_LATENCY lines up with i_ram_dout
  logic [RD_LATENCY:0]                     r_tg_vld;
  logic [RD_LATENCY:0][IDW-1:0]            r_tg_id;

  // write hazard pipeline: an entry lives from grant until WR_LATENCY cycles after issue
  logic [WR_LATENCY:0]                     r_hz_vld;
  logic [WR_LATENCY:0][ADDR_WIDTH-1:0]     r_hz_addr;

  // read return registers
  logic [NUM_REQ-1:0]                      r_rvalid;
  logic [DATA_WIDTH-1:0]                   r_rdata;

  logic [NUM_REQ-1:0]                      w_hazard;
  logic [NUM_REQ-1:0]                      w_elig;
  logic [NUM_REQ-1:0]                      w_gnt;
  logic                                    w_any;
  logic [IDW-1:0]                          w_gnt_id;
  logic [IDW:0]                            w_cand;
  logic                                    w_sel_we;
  logic [ADDR_WIDTH-1:0]                   w_sel_addr;
  logic [DATA_WIDTH-1:0]                   w_sel_din;
  logic [IDW-1:0]                          w_ptr_nxt;
  logic [NUM_REQ-1:0]                      w_ret_oh;

  // reads matching any live write address are held back; writes are never masked
  always_comb begin
    w_hazard = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int s = 0; s <= WR_LATENCY; s++) begin
        if (!i_we[k] && r_hz_vld[s] &&
            (i_addr[k*ADDR_WIDTH +: ADDR_WIDTH] == r_hz_addr[s])) begin
          w_hazard[k] = 1'b1;
        end
      end
    end
  end

  // rotating priority search starting at the pointer; captures the winner's fields
  always_comb begin
    w_elig     = i_req & ~w_hazard;
    w_gnt      = '0;
    w_any      = 1'b0;
    w_gnt_id   = '0;
    w_cand     = '0;
    w_sel_we   = 1'b0;
    w_sel_addr = '0;
    w_sel_din  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_cand = {1'b0, r_ptr} + (IDW+1)'(j);
      if (w_cand >= (IDW+1)'(NUM_REQ)) begin
        w_cand = w_cand - (IDW+1)'(NUM_REQ);
      end
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!w_any && (w_cand == (IDW+1)'(k)) && w_elig[k]) begin
          w_any      = 1'b1;
          w_gnt[k]   = 1'b1;
          w_gnt_id   = IDW'(k);
          w_sel_we   = i_we[k];
          w_sel_addr = i_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
          w_sel_din  = i_din[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
    w_ptr_nxt = (w_gnt_id == IDW'(NUM_REQ - 1)) ? '0 : w_gnt_id + IDW'(1);
  end

  // one-hot decode of the requester owning the data now on i_ram_dout
  always_comb begin
    w_ret_oh = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_ret_oh[k] = r_tg_vld[RD_LATENCY] && (r_tg_id[RD_LATENCY] == IDW'(k));
    end
  end

  // pointer advance and command register; addr/din hold across idle cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= '0;
      r_ram_en   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
    end else begin
      r_ram_en <= w_any;
      r_ram_we <= w_any & w_sel_we;
      if (w_any) begin
        r_ptr      <= w_ptr_nxt;
        r_ram_addr <= w_sel_addr;
        r_ram_din  <= w_sel_din;
      end
    end
  end

  // read tag and write hazard shift registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tg_vld  <= '0;
      r_tg_id   <= '0;
      r_hz_vld  <= '0;
      r_hz_addr <= '0;
    end else begin
      r_tg_vld[0]  <= w_any & ~w_sel_we;
      r_tg_id[0]   <= w_gnt_id;
      r_hz_vld[0]  <= w_any & w_sel_we;
      r_hz_addr[0] <= w_sel_addr;
      for (int s = 1; s <= RD_LATENCY; s++) begin
        r_tg_vld[s] <= r_tg_vld[s-1];
        r_tg_id[s]  <= r_tg_id[s-1];
      end
      for (int s = 1; s <= WR_LATENCY; s++) begin
        r_hz_vld[s]  <= r_hz_vld[s-1];
        r_hz_addr[s] <= r_hz_addr[s-1];
      end
    end
  end

  // route returned data to its issuer; data holds between returns
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_ret_oh;
      if (r_tg_vld[RD_LATENCY]) begin
        r_rdata <= i_ram_dout;
      end
    end
  end

`ifdef ARB_ECC_EN
  logic [1:0] r_rerror;
  logic [7:0] r_err_cnt;

  // error status follows the data; counter saturates at 255
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rerror  <= '0;
      r_err_cnt <= '0;
    end else if (r_tg_vld[RD_LATENCY]) begin
      r_rerror <= i_ram_error;
      if ((i_ram_error != 2'b00) && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign o_rerror  = r_rerror;
  assign o_err_cnt = r_err_cnt;
`endif

  assign o_gnt      = w_gnt;
  assign o_ram_en   = r_ram_en;
  assign o_ram_we   = r_ram_we;
  assign o_ram_addr = r_ram_addr;
  assign o_ram_din  = r_ram_din;
  assign o_rvalid   = r_rvalid;
  assign o_rdata    = r_rdata;

endmodule

// File: doc/ram_req_arbiter.md
Name: ram_req_arbiter

Overview:
- Shares one port of the dual-port memory controller among NUM_REQ requesters.
- Uses round-robin arbitration with a per-requester req/gnt handshake.
- Drives a registered RAM command. Tracks in-flight reads by requester ID and routes returned data to the issuing requester.
- Blocks a read to an address with an in-flight write until that write retires.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- DATA_WIDTH, 8, data width (same as the memory controller).
- ADDR_WIDTH, 4, address width.
- RD_LATENCY, 2, memory read latency in cycles (>=1).
- WR_LATENCY, 1, memory write latency in cycles (>=1).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  NUM_REQ  request per requester; held until granted.
- i_we  in  NUM_REQ  1 = write, 0 = read, per requester.
- i_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester k in slice k.
- i_din  in  NUM_REQ*DATA_WIDTH  packed write data.
- o_gnt  out  NUM_REQ  one-hot grant, combinational; acceptance = i_req[k] & o_gnt[k].
- o_ram_en  out  1  memory enable (registered).
- o_ram_we  out  1  memory write enable (registered).
- o_ram_addr  out  ADDR_WIDTH  memory address (registered).
- o_ram_din  out  DATA_WIDTH  memory write data (registered).
- i_ram_dout  in  DATA_WIDTH  memory read data.
- o_rvalid  out  NUM_REQ  one-hot read-return strobe.
- o_rdata  out  DATA_WIDTH  read-return data, valid when any o_rvalid bit is set.

Behaviour:
- Reset (asynchronous, immediate) sets:
  - all registered outputs = 0;
  - round-robin pointer = 0;
  - read tag pipeline and write hazard pipeline cleared.
- Reset mid-operation: in-flight reads are dropped and never returned.
- Arbitration, in the cycle t where the request is accepted:
  - Eligible set = i_req & ~hazard_mask.
  - Search starts at the pointer and proceeds upward with wrap-around. The first eligible requester k gets o_gnt[k] = 1.
  - At most one grant per cycle. If the eligible set is empty, o_gnt = 0.
  - Pointer update on a grant: (k+1) mod NUM_REQ. No grant: pointer unchanged.
- Command issue:
  - The granted request's we/addr/din are registered onto o_ram_* with o_ram_en = 1 in cycle t+1.
  - With no grant, o_ram_en = 0 and o_ram_we = 0; addr/din hold their last values.
  - One command per cycle; no back-to-back gaps.
- Read return:
  - The memory presents data on i_ram_dout RD_LATENCY cycles after the edge at which it samples en, i.e. in cycle t+1+RD_LATENCY.
  - A tag pipeline of depth RD_LATENCY+1 carries {valid, requester ID}.
  - In cycle t+2+RD_LATENCY: o_rvalid[k] = 1 for one cycle and o_rdata = registered i_ram_dout.
  - Read-to-data latency from grant = RD_LATENCY+2 cycles. Returns are in issue order.
  - o_rdata holds its value when o_rvalid = 0.
- Write hazard:
  - A pipeline of depth WR_LATENCY+1 holds {valid, addr} of each granted write from its grant until WR_LATENCY cycles after issue.
  - hazard_mask[k] = 1 when ~i_we[k] and i_addr[k] matches any valid entry.
  - Writes are never masked. Write-after-write to the same address is allowed.
  - The masked read becomes eligible the cycle after the matching entry retires. Other requesters may win meanwhile.
- Simultaneous requests: all requesters requesting every cycle each get served once per NUM_REQ cycles.
- Requester dropping i_req while not granted: legal, no effect.
- Changing fields while i_req is high and ungranted: legal; the fields sampled are those present at the grant cycle.

Optional Feature:
- Macro: ARB_ECC_EN.
- With the macro defined:
  - Adds input i_ram_error[1:0], aligned with i_ram_dout.
  - Adds output o_rerror[1:0], registered alongside o_rdata.
  - Adds output o_err_cnt[7:0]: increments on each returned read with o_rerror != 2'b00, saturates at 255, reset to 0.
- Without the macro: none of these ports or the counter exist. Read return behaviour is otherwise identical.

Test Plan:
- Reset then idle → o_gnt = 0, o_ram_en = 0, o_rvalid = 0, o_rdata = 0 for 10 cycles.
- NUM_REQ=2, both i_req = 1 continuously, both reads → grants alternate 0,1,0,1. o_rvalid alternates with the same order, RD_LATENCY+2 = 4 cycles after each grant.
- Req0 writes addr 3 data 8'hA5, then req0 reads addr 3 → read data 8'hA5 returns to req0 only, with o_rvalid = 2'b01.
- Req0 writes addr 5 while req1 reads addr 5 in the next cycle → req1 is not granted until the write entry retires (WR_LATENCY+1 cycles). The read then returns the written value.
- Reset asserted with 2 reads in flight → no o_rvalid after reset releases. The pointer is 0, so requester 0 wins the first simultaneous request.
- ARB_ECC_EN defined, i_ram_error = 2'b10 on a returned read → o_rerror = 2'b10 with o_rvalid, o_err_cnt 0→1. 300 errored reads give o_err_cnt = 255.
